// File: rtl/dbf_pkg.sv
// Shared types and sizing helpers for the DBF weight chain (weight generation and application).
package dbf_pkg;

    localparam int DW      = 16;
    localparam int Q14_ONE = 16384;
    localparam int PW      = 2 * DW;
    localparam int SW      = 2 * DW + 1;

    typedef logic signed [DW-1:0] sample_t;
    typedef logic signed [DW-1:0] weight_t;
    typedef logic signed [PW-1:0] prod_t;
    typedef logic signed [SW-1:0] sum_t;

    // Control flags that ride alongside each beat through the multiplier pipeline.
    typedef struct packed {
        logic first;
        logic last;
        logic err;
    } beat_tag_t;

    function automatic int acc_w(input int dw, input int nch);
        return 2 * dw + 1 + $clog2(nch);
    endfunction

endpackage

// File: rtl/dbf_weight_apply_if.sv
// Per-channel sample/weight input stream and beam output stream of dbf_weight_apply.
interface dbf_weight_apply_if #(
    parameter int DW = 16
);

    logic signed [DW-1:0] din_re;
    logic signed [DW-1:0] din_im;
    logic signed [DW-1:0] w_re;
    logic signed [DW-1:0] w_im;
    logic                 din_valid;
    logic                 din_last;

    logic signed [DW-1:0] beam_re;
    logic signed [DW-1:0] beam_im;
    logic                 beam_valid;
    logic                 align_err;
    logic                 sat_flag;

    modport master (
        output din_re, din_im, w_re, w_im, din_valid, din_last,
        input  beam_re, beam_im, beam_valid, align_err, sat_flag
    );

    modport slave (
        input  din_re, din_im, w_re, w_im, din_valid, din_last,
        output beam_re, beam_im, beam_valid, align_err, sat_flag
    );

endinterface

// File: rtl/dbf_cmult.sv
// Two-stage pipelined complex multiplier: S1 registers the four partial products, S2 the re/im sums.
module dbf_cmult #(
    parameter int DW    = dbf_pkg::DW,
    parameter int TAG_W = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_i,
    input  logic [TAG_W-1:0]       tag_i,
    input  logic signed [DW-1:0]   a_re_i,
    input  logic signed [DW-1:0]   a_im_i,
    input  logic signed [DW-1:0]   b_re_i,
    input  logic signed [DW-1:0]   b_im_i,
    output logic                   valid_o,
    output logic [TAG_W-1:0]       tag_o,
    output logic signed [2*DW:0]   p_re_o,
    output logic signed [2*DW:0]   p_im_o
);

    localparam int PW = 2 * DW;
    localparam int SW = 2 * DW + 1;

    logic                 v1_q, v1_d;
    logic                 v2_q, v2_d;
    logic [TAG_W-1:0]     tag1_q, tag2_q;
    logic signed [PW-1:0] ac_q, bd_q, ad_q, bc_q;
    logic signed [PW-1:0] ac_d, bd_d, ad_d, bc_d;
    logic signed [SW-1:0] re_q, im_q, re_d, im_d;

    always_comb begin
        v1_d = valid_i;
        v2_d = v1_q;
        ac_d = PW'(a_re_i) * PW'(b_re_i);
        bd_d = PW'(a_im_i) * PW'(b_im_i);
        ad_d = PW'(a_re_i) * PW'(b_im_i);
        bc_d = PW'(a_im_i) * PW'(b_re_i);
        re_d = SW'(ac_q) - SW'(bd_q);
        im_d = SW'(ad_q) + SW'(bc_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
        end
    end

    // NOTE: datapath and tag registers carry no reset; only the valid bits
    // qualify them, so stale contents are never observed downstream.
    always_ff @(posedge clk) begin
        tag1_q <= tag_i;
        tag2_q <= tag1_q;
        ac_q   <= ac_d;
        bd_q   <= bd_d;
        ad_q   <= ad_d;
        bc_q   <= bc_d;
        re_q   <= re_d;
        im_q   <= im_d;
    end

    assign valid_o = v2_q;
    assign tag_o   = tag2_q;
    assign p_re_o  = re_q;
    assign p_im_o  = im_q;

endmodule

// File: rtl/dbf_weight_apply.sv
// Applies complex DBF weights per channel and sums NCH channels into one 16-bit beam sample.
// Build option: define DBF_APPLY_SAT_EN to saturate the output (and drive sat_flag) instead of wrapping.
module dbf_weight_apply #(
    parameter int NCH       = 8,
    parameter int DW        = dbf_pkg::DW,
    parameter int OUT_SHIFT = 14
) (
    input logic              clk,
    input logic              rst,
    dbf_weight_apply_if.slave bus
);

    localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int SW    = 2 * DW + 1;
    localparam int ACC_W = dbf_pkg::acc_w(DW, NCH);
    localparam int RW    = ACC_W + 1;
    localparam int TAG_W = $bits(dbf_pkg::beat_tag_t);

    localparam logic [CW-1:0]        LAST_CH = CW'(NCH - 1);
    localparam logic signed [RW-1:0] RND     = RW'(1) << (OUT_SHIFT - 1);

`ifdef DBF_APPLY_SAT_EN
    localparam logic signed [RW-1:0] SAT_MAX = RW'((64'sd1 <<< (DW - 1)) - 64'sd1);
    localparam logic signed [RW-1:0] SAT_MIN = ~SAT_MAX;
`endif

    // Returns {clipped, value} for a shifted accumulator value.
    function automatic logic [DW:0] reduce_out(input logic signed [RW-1:0] v);
`ifdef DBF_APPLY_SAT_EN
        if (v > SAT_MAX) begin
            return {1'b1, SAT_MAX[DW-1:0]};
        end else if (v < SAT_MIN) begin
            return {1'b1, SAT_MIN[DW-1:0]};
        end
        return {1'b0, v[DW-1:0]};
`else
        return {1'b0, v[DW-1:0]};
`endif
    endfunction

    // Stage 0: channel counter and alignment check
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  at_end;
    logic                  beat_err;
    dbf_pkg::beat_tag_t    tag0;

    assign at_end   = (cnt_q == LAST_CH);
    assign beat_err = bus.din_valid && (bus.din_last != at_end);

    // NOTE: every combinational output gets its default first so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (bus.din_valid) begin
            cnt_d = (beat_err || at_end) ? '0 : cnt_q + 1'b1;
        end
        tag0.first = (cnt_q == '0);
        tag0.last  = at_end && bus.din_last;
        tag0.err   = beat_err;
    end

    // NOTE: sequential state always uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Stages 1-2: complex multiply
    logic                  s2_valid;
    dbf_pkg::beat_tag_t    s2_tag;
    logic signed [SW-1:0]  s2_re, s2_im;

    dbf_cmult #(
        .DW    (DW),
        .TAG_W (TAG_W)
    ) u_cmult (
        .clk     (clk),
        .rst     (rst),
        .valid_i (bus.din_valid),
        .tag_i   (tag0),
        .a_re_i  (bus.din_re),
        .a_im_i  (bus.din_im),
        .b_re_i  (bus.w_re),
        .b_im_i  (bus.w_im),
        .valid_o (s2_valid),
        .tag_o   (s2_tag),
        .p_re_o  (s2_re),
        .p_im_o  (s2_im)
    );

    // Stage 3: accumulate; the first channel of a group loads instead of adding
    logic signed [ACC_W-1:0] acc_re_q, acc_re_d;
    logic signed [ACC_W-1:0] acc_im_q, acc_im_d;
    logic                    done3_q, done3_d;
    logic                    err3_q, err3_d;

    always_comb begin
        acc_re_d = acc_re_q;
        acc_im_d = acc_im_q;
        done3_d  = s2_valid && s2_tag.last;
        err3_d   = s2_valid && s2_tag.err;
        if (s2_valid) begin
            if (s2_tag.first) begin
                acc_re_d = ACC_W'(s2_re);
                acc_im_d = ACC_W'(s2_im);
            end else begin
                acc_re_d = acc_re_q + ACC_W'(s2_re);
                acc_im_d = acc_im_q + ACC_W'(s2_im);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_re_q <= '0;
            acc_im_q <= '0;
            done3_q  <= 1'b0;
            err3_q   <= 1'b0;
        end else begin
            acc_re_q <= acc_re_d;
            acc_im_q <= acc_im_d;
            done3_q  <= done3_d;
            err3_q   <= err3_d;
        end
    end

    // Stage 4: round half-up, arithmetic shift, reduce to DW bits
    logic signed [RW-1:0] sh_re, sh_im;
    logic [DW:0]          red_re, red_im;
    logic signed [DW-1:0] beam_re_q, beam_re_d;
    logic signed [DW-1:0] beam_im_q, beam_im_d;
    logic                 beam_valid_q, beam_valid_d;
    logic                 align_err_q, align_err_d;
    logic                 sat_q, sat_d;

    always_comb begin
        sh_re        = (RW'(acc_re_q) + RND) >>> OUT_SHIFT;
        sh_im        = (RW'(acc_im_q) + RND) >>> OUT_SHIFT;
        red_re       = reduce_out(sh_re);
        red_im       = reduce_out(sh_im);
        beam_re_d    = beam_re_q;
        beam_im_d    = beam_im_q;
        beam_valid_d = done3_q;
        align_err_d  = err3_q;
        sat_d        = 1'b0;
        if (done3_q) begin
            beam_re_d = red_re[DW-1:0];
            beam_im_d = red_im[DW-1:0];
            sat_d     = red_re[DW] || red_im[DW];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beam_re_q    <= '0;
            beam_im_q    <= '0;
            beam_valid_q <= 1'b0;
            align_err_q  <= 1'b0;
            sat_q        <= 1'b0;
        end else begin
            beam_re_q    <= beam_re_d;
            beam_im_q    <= beam_im_d;
            beam_valid_q <= beam_valid_d;
            align_err_q  <= align_err_d;
            sat_q        <= sat_d;
        end
    end

    assign bus.beam_re    = beam_re_q;
    assign bus.beam_im    = beam_im_q;
    assign bus.beam_valid = beam_valid_q;
    assign bus.align_err  = align_err_q;
    assign bus.sat_flag   = sat_q;

endmodule
